// File: rtl/addh_serial_seq.sv
// rtl/addh_serial_seq.sv - bit-serial add/increment sequencer over a shared half-adder pair
//
// Accepts one operand pair per request while idle and pushes it LSB-first
// through a single full-add bit slice for WIDTH cycles. The registered sum and
// carry-out are then presented, together with a one-cycle completion pulse.
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    asynchronous active-high reset
//   start_i  request strobe, honoured only while ready_o=1
//   op_i     0: a_i + b_i, 1: a_i + 1 (b_i ignored)
//   a_i      operand A, captured on the accepting edge
//   b_i      operand B, captured on the accepting edge
//   ready_o  high while idle
//   done_o   one-cycle pulse when s_o/co_o are updated
//   s_o      registered sum, held until the next done_o
//   co_o     registered carry-out of bit WIDTH-1
module addh_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             co_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  // Single bit slice: two cascaded half adders.
  logic bit_p;
  logic bit_s;
  logic bit_c;
  assign bit_p = sa_q[0] ^ sb_q[0];
  assign bit_s = bit_p ^ c_q;
  assign bit_c = (sa_q[0] & sb_q[0]) | (c_q & bit_p);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    r_d     = r_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    co_d    = co_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          sa_d    = a_i;
          // Increment reuses the adder with B=0 and carry-in 1.
          sb_d    = op_i ? '0 : b_i;
          c_d     = op_i;
          cnt_d   = '0;
          r_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        c_d   = bit_c;
        r_d   = {bit_s, r_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Result includes the bit computed on this very edge.
          s_d     = {bit_s, r_q[WIDTH-1:1]};
          co_d    = bit_c;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered copies of the next state so outputs come
    // straight from flops.
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign s_o     = s_q;
  assign co_o    = co_q;

endmodule
